// File: rtl/opl3_pkg.sv
// ---------------------------------------------------------------------------
// opl3_pkg
// Shared types and defaults for the OPL3 core.
//   opl3_reg_wr_t       : register-write pulse consumed by the OPL3 register file
//   opl3_reg_payload_t  : the same fields without the valid bit (FIFO storage)
//   opl3_status_t       : host-visible status byte layout
//   HOST_FIFO_DEPTH     : default host write-buffer depth
//   HOST_MIN_WR_INTERVAL: default minimum clk cycles between register writes
// ---------------------------------------------------------------------------
package opl3_pkg;

  localparam int HOST_FIFO_DEPTH      = 8;
  localparam int HOST_MIN_WR_INTERVAL = 32;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

  typedef struct packed {
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_payload_t;

  // Bit 7 is the combined timer IRQ, bits 6/5 the individual timer flags.
  typedef struct packed {
    logic       irq;
    logic       ft1;
    logic       ft2;
    logic [4:0] reserved;
  } opl3_status_t;

endpackage

// File: rtl/opl3_host_if_if.sv
// ---------------------------------------------------------------------------
// opl3_host_bus_if
// YMF262-style CPU port between the board-level bus bridge and opl3_host_if.
//   cs_n, wr_n, rd_n : active-low strobes, synchronous to the core clock
//   address          : {A1 = bank select, A0 = 0:index / 1:data}
//   din              : host write data
//   dout             : host read data (status)
// Modports: master = bus bridge side, slave = opl3_host_if side.
// ---------------------------------------------------------------------------
interface opl3_host_bus_if;

  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic [1:0] address;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (
    output cs_n, wr_n, rd_n, address, din,
    input  dout
  );

  modport slave (
    input  cs_n, wr_n, rd_n, address, din,
    output dout
  );

endinterface

// File: rtl/opl3_host_wr_fifo.sv
// ---------------------------------------------------------------------------
// opl3_host_wr_fifo
// Synchronous FIFO holding pending register writes (payload only, no valid).
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write push_data when not full (ignored when full)
//   pop          : advance read pointer when not empty (ignored when empty)
//   pop_data     : head entry, valid whenever empty is low
//   full, empty  : occupancy flags, derived from the registered count only
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module opl3_host_wr_fifo
  import opl3_pkg::*;
#(
  parameter int DEPTH = HOST_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  opl3_reg_payload_t push_data,
  input  logic              pop,
  output opl3_reg_payload_t pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  opl3_reg_payload_t mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/opl3_host_if.sv
// ---------------------------------------------------------------------------
// opl3_host_if
// Host-side producer of OPL3 register writes. Latches index writes, buffers
// data writes in a FIFO and drains them no faster than one per
// MIN_WR_INTERVAL clocks as single-cycle opl3_reg_wr pulses.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : CPU port (slave modport): cs_n, wr_n, rd_n, address, din, dout
//   irq_n        : timer IRQ, active low
//   ft1, ft2     : timer 1/2 overflow flags
//   opl3_reg_wr  : {valid, bank_num, address, data}; fields hold last write
//   fifo_full    : write buffer full
//   overflow     : sticky, a data write was dropped because the buffer was full
// Build option: define OPL3_STATUS_READ_EN to return the status byte on
// reads of A0=0; otherwise dout is tied to zero and the status inputs are unused.
// ---------------------------------------------------------------------------
module opl3_host_if
  import opl3_pkg::*;
#(
  parameter int FIFO_DEPTH      = HOST_FIFO_DEPTH,
  parameter int MIN_WR_INTERVAL = HOST_MIN_WR_INTERVAL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  opl3_host_bus_if.slave        bus,
  input  logic                  irq_n,
  input  logic                  ft1,
  input  logic                  ft2,
  output opl3_reg_wr_t          opl3_reg_wr,
  output logic                  fifo_full,
  output logic                  overflow
);

  // A one-bit counter still works for MIN_WR_INTERVAL == 1 (reload of 0).
  localparam int PACE_W = (MIN_WR_INTERVAL > 1) ? $clog2(MIN_WR_INTERVAL) : 1;
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(MIN_WR_INTERVAL - 1);

  logic              wr_active;
  logic              wr_active_q;
  logic              wr_event;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [7:0]        index_reg;
  logic              idx_bank;
  logic [PACE_W-1:0] pace_cnt;
  opl3_reg_payload_t push_data;
  opl3_reg_payload_t pop_data;

  // A held-low strobe yields exactly one event: only the first active cycle counts.
  assign wr_active = !bus.cs_n && !bus.wr_n;
  assign wr_event  = wr_active && !wr_active_q;
  assign push      = wr_event && bus.address[0];
  assign pop       = !fifo_empty && (pace_cnt == '0);

  // The bank travels with the index write, not with the data write.
  assign push_data = '{bank_num: idx_bank, address: index_reg, data: bus.din};

  opl3_host_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_active_q <= 1'b0;
      index_reg   <= '0;
      idx_bank    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_active_q <= wr_active;
      if (wr_event && !bus.address[0]) begin
        index_reg <= bus.din;
        idx_bank  <= bus.address[1];
      end
      if (push && fifo_full) overflow <= 1'b1;
    end
  end

  // The pace counter runs down after each pop; a new pop waits for zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pace_cnt    <= '0;
      opl3_reg_wr <= '0;
    end else begin
      opl3_reg_wr.valid <= pop;
      if (pop) begin
        pace_cnt             <= PACE_RELOAD;
        opl3_reg_wr.bank_num <= pop_data.bank_num;
        opl3_reg_wr.address  <= pop_data.address;
        opl3_reg_wr.data     <= pop_data.data;
      end else if (pace_cnt != '0) begin
        pace_cnt <= pace_cnt - 1'b1;
      end
    end
  end

`ifdef OPL3_STATUS_READ_EN
  opl3_status_t status;

  assign status = '{irq: ~irq_n, ft1: ft1, ft2: ft2, reserved: 5'b0};

  // Reads are side-effect free; dout returns to zero outside a status read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.dout <= '0;
    end else if (!bus.cs_n && !bus.rd_n && !bus.address[0]) begin
      bus.dout <= status;
    end else begin
      bus.dout <= '0;
    end
  end
`else
  logic unused_status;

  assign bus.dout      = 8'h00;
  assign unused_status = &{1'b0, bus.rd_n, irq_n, ft1, ft2};
`endif

endmodule

// File: tb/tb_opl3_host_if.sv
// ---------------------------------------------------------------------------
// tb_opl3_host_if
// Self-checking bench for opl3_host_if. A reference model predicts the
// register-write pulses (cycle and contents), buffer occupancy and overflow
// from the host bus activity; a monitor records the pulses the DUT produces.
// ---------------------------------------------------------------------------
module tb_opl3_host_if;
  import opl3_pkg::*;

  localparam int DEPTH  = 8;
  localparam int MIN_IV = 32;
  localparam int DRAIN  = 400;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } pulse_t;

  typedef struct {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  logic         clk;
  logic         reset_n;
  logic         irq_n;
  logic         ft1;
  logic         ft2;
  opl3_reg_wr_t opl3_reg_wr;
  logic         fifo_full;
  logic         overflow;

  opl3_host_bus_if bus ();

  opl3_host_if #(
    .FIFO_DEPTH     (DEPTH),
    .MIN_WR_INTERVAL(MIN_IV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .irq_n      (irq_n),
    .ft1        (ft1),
    .ft2        (ft2),
    .opl3_reg_wr(opl3_reg_wr),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_drive_cyc = 0;
  pulse_t exp_log[$];
  pulse_t act_log[$];

  // Reference model state: pending writes and time of the last accepted pulse.
  entry_t     m_q[$];
  logic       m_prev_active = 1'b0;
  logic       m_bank = 1'b0;
  logic [7:0] m_idx = 8'h00;
  logic       m_ovf = 1'b0;
  bit         m_popped = 1'b0;
  int         m_last_pop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One register write may leave the buffer per MIN_IV cycles; a data write
  // arriving while DEPTH writes are pending is lost.
  task automatic model_step();
    entry_t e;
    pulse_t p;
    int     pre_size;
    logic   active;
    logic   ev;
    if (!reset_n) begin
      m_q.delete();
      m_prev_active = 1'b0;
      m_bank        = 1'b0;
      m_idx         = 8'h00;
      m_ovf         = 1'b0;
      m_popped      = 1'b0;
    end else begin
      active        = !bus.cs_n && !bus.wr_n;
      ev            = active && !m_prev_active;
      m_prev_active = active;
      pre_size      = m_q.size();
      if (pre_size > 0 && (!m_popped || (cyc - m_last_pop) >= MIN_IV)) begin
        e          = m_q.pop_front();
        m_popped   = 1'b1;
        m_last_pop = cyc;
        p          = '{cyc, e.bank, e.addr, e.data};
        exp_log.push_back(p);
      end
      if (ev && bus.address[0]) begin
        if (pre_size == DEPTH) m_ovf = 1'b1;
        else m_q.push_back('{m_bank, m_idx, bus.din});
      end else if (ev) begin
        m_idx  = bus.din;
        m_bank = bus.address[1];
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    pulse_t p;
    forever begin
      @(negedge clk);
      if (opl3_reg_wr.valid === 1'b1) begin
        p = '{cyc, opl3_reg_wr.bank_num, opl3_reg_wr.address, opl3_reg_wr.data};
        act_log.push_back(p);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    exp_log.delete();
    act_log.delete();
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(posedge clk);
    #1;
    last_drive_cyc = cyc;
    bus.address = a;
    bus.din     = d;
    bus.cs_n    = 1'b0;
    bus.wr_n    = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (opl3_reg_wr !== '0) begin errors++; $display("[TB] FAIL reset_reg_wr got %h want 0", opl3_reg_wr); end
    if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", fifo_full); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got %h want 00", bus.dout); end
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks += 3;
    if (opl3_reg_wr.valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid got %b want 0", opl3_reg_wr.valid); end
    if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_full got %b want 0", fifo_full); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_overflow got %b want 0", overflow); end
  endtask

  // Index then data write; pulse two cycles after the data write, bank taken from the index write.
  task automatic test_index_data();
    logic [1:0] idx_a   [2] = '{2'b00, 2'b10};
    logic [7:0] idx_d   [2] = '{8'hB0, 8'h05};
    logic [7:0] dat_d   [2] = '{8'h2A, 8'h01};
    logic       exp_bank[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      clear_logs();
      host_write(idx_a[i], idx_d[i], 1);
      host_write(2'b01, dat_d[i], 1);
      repeat (6) @(negedge clk);
      checks++;
      if (act_log.size() != 1) begin
        errors++; $display("[TB] FAIL idx_data_count case %0d got %0d want 1", i, act_log.size());
      end else begin
        checks += 4;
        if (act_log[0].cyc != last_drive_cyc + 2) begin errors++; $display("[TB] FAIL idx_data_latency case %0d got %0d want %0d", i, act_log[0].cyc, last_drive_cyc + 2); end
        if (act_log[0].bank !== exp_bank[i]) begin errors++; $display("[TB] FAIL idx_data_bank case %0d got %b want %b", i, act_log[0].bank, exp_bank[i]); end
        if (act_log[0].addr !== idx_d[i]) begin errors++; $display("[TB] FAIL idx_data_addr case %0d got %h want %h", i, act_log[0].addr, idx_d[i]); end
        if (act_log[0].data !== dat_d[i]) begin errors++; $display("[TB] FAIL idx_data_data case %0d got %h want %h", i, act_log[0].data, dat_d[i]); end
      end
      repeat (MIN_IV + 4) @(posedge clk);
    end
  endtask

  // Three data writes reusing one index; pulses in order, exactly MIN_IV apart.
  task automatic test_back_to_back();
    logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    host_write(2'b00, 8'h20, 1);
    for (int i = 0; i < 3; i++) host_write(2'b01, vals[i], 1);
    repeat (4 * MIN_IV) @(negedge clk);
    checks++;
    if (act_log.size() != 3) begin
      errors++; $display("[TB] FAIL b2b_count got %0d want 3", act_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (act_log[i].addr !== 8'h20 || act_log[i].bank !== 1'b0) begin errors++; $display("[TB] FAIL b2b_addr %0d got %b/%h want 0/20", i, act_log[i].bank, act_log[i].addr); end
        if (act_log[i].data !== vals[i]) begin errors++; $display("[TB] FAIL b2b_data %0d got %h want %h", i, act_log[i].data, vals[i]); end
        if (i > 0) begin
          checks++;
          if (act_log[i].cyc - act_log[i-1].cyc != MIN_IV) begin errors++; $display("[TB] FAIL b2b_spacing %0d got %0d want %0d", i, act_log[i].cyc - act_log[i-1].cyc, MIN_IV); end
        end
      end
    end
  endtask

  // One write primes the pace counter, then nine writes arrive before any further drain.
  task automatic test_overflow();
    clear_logs();
    host_write(2'b00, 8'h40, 1);
    host_write(2'b01, 8'h00, 1);
    for (int i = 1; i <= 9; i++) begin
      host_write(2'b01, 8'(i), 1);
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_at7 got %b want 0", fifo_full); end
      end
      if (i == 8) begin
        checks += 2;
        if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_at8 got %b want 1", fifo_full); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b want 0", overflow); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
    repeat (DRAIN) @(negedge clk);
    checks += 3;
    if (act_log.size() != 9) begin errors++; $display("[TB] FAIL ovf_pulse_count got %0d want 9", act_log.size()); end
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow); end
    if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_after_drain got %b want 0", fifo_full); end
    for (int i = 0; i < act_log.size() && i < 9; i++) begin
      checks++;
      if (act_log[i].data !== 8'(i)) begin errors++; $display("[TB] FAIL ovf_data %0d got %h want %h", i, act_log[i].data, 8'(i)); end
    end
  endtask

  // Held strobe gives one write; reset mid-drain discards everything queued.
  task automatic test_held_and_reset();
    bit seen;
    int rel;
    clear_logs();
    host_write(2'b00, 8'h60, 1);
    host_write(2'b01, 8'hAA, 10);
    for (int i = 1; i <= 5; i++) host_write(2'b01, 8'(i), 1);
    @(negedge clk);
    checks++;
    if (act_log.size() != 1) begin errors++; $display("[TB] FAIL held_single_push got %0d pulses want 1", act_log.size()); end
    seen = 1'b0;
    for (int t = 0; t < 2 * MIN_IV && !seen; t++) begin
      @(negedge clk);
      if (opl3_reg_wr.valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL drain_pulse_timeout got none want 1"); end
    #1 reset_n = 1'b0;
    #1;
    checks += 3;
    if (opl3_reg_wr.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_valid got %b want 0", opl3_reg_wr.valid); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_overflow got %b want 0", overflow); end
    if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_full got %b want 0", fifo_full); end
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    rel = cyc;
    repeat (DRAIN) @(negedge clk);
    checks += 2;
    if (act_log.size() != 2) begin errors++; $display("[TB] FAIL reset_discard got %0d pulses want 2", act_log.size()); end
    if (act_log.size() > 0 && act_log[act_log.size()-1].cyc > rel) begin errors++; $display("[TB] FAIL pulse_after_reset got cycle %0d want <= %0d", act_log[act_log.size()-1].cyc, rel); end
    checks += 2;
    if (act_log.size() >= 1 && act_log[0].data !== 8'hAA) begin errors++; $display("[TB] FAIL held_data got %h want AA", act_log[0].data); end
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_overflow got %b want 0", overflow); end
  endtask

  // Status reads: fixed case then random flag patterns; reads never create writes.
  task automatic test_status();
    logic [7:0] want;
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        irq_n = 1'b0; ft1 = 1'b1; ft2 = 1'b0;
      end else begin
        irq_n = 1'($urandom); ft1 = 1'($urandom); ft2 = 1'($urandom);
      end
`ifdef OPL3_STATUS_READ_EN
      want = {~irq_n, ft1, ft2, 5'b00000};
`else
      want = 8'h00;
`endif
      @(posedge clk);
      #1;
      bus.address = {1'($urandom), 1'b0};
      bus.cs_n    = 1'b0;
      bus.rd_n    = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.dout !== want) begin errors++; $display("[TB] FAIL status_read %0d got %h want %h", i, bus.dout, want); end
      bus.address = 2'b01;
      @(posedge clk);
      #1;
      checks++;
      if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL status_a0_read %0d got %h want 00", i, bus.dout); end
      bus.cs_n = 1'b1;
      bus.rd_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL status_idle %0d got %h want 00", i, bus.dout); end
    end
    checks++;
    if (act_log.size() != 0) begin errors++; $display("[TB] FAIL read_side_effect got %0d pulses want 0", act_log.size()); end
  endtask

  // Random mix of index writes, data writes, held strobes and idle gaps.
  task automatic test_random();
    int op;
    clear_logs();
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 2) host_write({1'($urandom), 1'b0}, 8'($urandom), 1);
      else if (op < 9) host_write({1'($urandom), 1'b1}, 8'($urandom), $urandom_range(1, 3));
      else repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    @(negedge clk);
    checks += 2;
    if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow got %b want %b", overflow, m_ovf); end
    if (fifo_full !== (m_q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rand_full got %b want %b", fifo_full, m_q.size() == DEPTH); end
    repeat (DRAIN) @(negedge clk);
    checks++;
    if (act_log.size() != exp_log.size()) begin errors++; $display("[TB] FAIL rand_count got %0d want %0d", act_log.size(), exp_log.size()); end
    for (int i = 0; i < act_log.size() && i < exp_log.size(); i++) begin
      checks++;
      if (act_log[i] != exp_log[i]) begin
        errors++;
        $display("[TB] FAIL rand_pulse %0d got c%0d b%b a%h d%h want c%0d b%b a%h d%h", i,
                 act_log[i].cyc, act_log[i].bank, act_log[i].addr, act_log[i].data,
                 exp_log[i].cyc, exp_log[i].bank, exp_log[i].addr, exp_log[i].data);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    irq_n       = 1'b1;
    ft1         = 1'b0;
    ft2         = 1'b0;
    bus.cs_n    = 1'b1;
    bus.wr_n    = 1'b1;
    bus.rd_n    = 1'b1;
    bus.address = 2'b00;
    bus.din     = 8'h00;
    test_reset();
    test_index_data();
    test_back_to_back();
    test_overflow();
    test_held_and_reset();
    test_status();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
